// File: rtl/icache_dm_ro_if.sv
// Fetch-port and line-fill bus of the read-only instruction cache.
// The slave side is the cache; the master side is the core plus instruction memory.
interface icache_dm_ro_if;
    logic         proc_read;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic [27:0]  mem_addr;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport slave (
        input  proc_read, proc_addr, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_addr
    );

    modport master (
        output proc_read, proc_addr, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_addr
    );
endinterface

// File: rtl/icache_dm_ro.sv
// Direct-mapped, read-only instruction cache with 4-word lines, zero-latency hits,
// a single outstanding line fill and saturating hit/miss counters.
module icache_dm_ro #(
    parameter int INDEX_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    icache_dm_ro_if.slave    bus,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 28 - INDEX_W;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FETCH = 1'b1;

    logic [0:0]       state;
    logic [27:0]      miss_line;
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_arr  [LINES];
    logic [127:0]     data_arr [LINES];

    logic [1:0]         offset;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] fill_index;
    logic [TAG_W-1:0]   fill_tag;
    logic [127:0]       line;
    logic               hit;
    logic               miss;
    logic               fill;

    assign offset     = bus.proc_addr[1:0];
    assign index      = bus.proc_addr[INDEX_W+1:2];
    assign tag        = bus.proc_addr[29:INDEX_W+2];
    assign fill_index = miss_line[INDEX_W-1:0];
    assign fill_tag   = miss_line[27:INDEX_W];
    assign line       = data_arr[index];

    // Lookups only count in IDLE; while a fill is outstanding the fetch port is ignored.
    assign hit  = (state == S_IDLE) && bus.proc_read && valid[index] && (tag_arr[index] == tag);
    assign miss = (state == S_IDLE) && bus.proc_read && !hit;
    assign fill = (state == S_FETCH) && bus.mem_ready;

    assign bus.proc_stall = (state == S_FETCH) || miss;
    assign bus.proc_rdata = hit ? line[{offset, 5'b0} +: 32] : 32'h0;
    assign bus.mem_read   = (state == S_FETCH);
    assign bus.mem_addr   = miss_line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            miss_line <= '0;
            valid     <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            if (hit && (hit_cnt != '1))
                hit_cnt <= hit_cnt + CNT_W'(1);
            if (miss) begin
                miss_line <= bus.proc_addr[29:2];
                state     <= S_FETCH;
                if (miss_cnt != '1)
                    miss_cnt <= miss_cnt + CNT_W'(1);
            end
            if (fill) begin
                valid[fill_index] <= 1'b1;
                state             <= S_IDLE;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_arr[fill_index]  <= fill_tag;
            data_arr[fill_index] <= bus.mem_rdata;
        end
    end
endmodule

// File: doc/icache_dm_ro.md
Name: icache_dm_ro

Overview:
- Read-only, direct-mapped instruction cache between the single-cycle MIPS fetch port and a slower instruction memory.
- The existing core reads its instruction ROM combinationally. This block lets the core fetch from a multi-cycle memory by returning a stall until the instruction is available.
- Cache size is 2^INDEX_W lines of 4 words each (128-bit lines).
- Includes saturating hit and miss counters for performance evaluation.

Parameters:
- INDEX_W, 3, number of index bits; the cache has 2^INDEX_W lines.
- CNT_W, 16, width of the hit and miss counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- proc_read  in  1  the core requests an instruction word this cycle.
- proc_addr  in  30  word address (byte address [31:2]).
- proc_rdata  out  32  instruction word; valid when proc_read=1 and proc_stall=0.
- proc_stall  out  1  the core must hold its PC and proc_addr.
- mem_read  out  1  line-fill request to instruction memory.
- mem_addr  out  28  line address, equal to the miss address [29:2].
- mem_rdata  in  128  fill data; word 0 in bits [31:0], word 3 in bits [127:96].
- mem_ready  in  1  one-cycle pulse; mem_rdata is valid in this cycle.
- hit_cnt  out  CNT_W  number of hit lookups, saturating.
- miss_cnt  out  CNT_W  number of misses, saturating.

Behaviour:
- Address split:
  - offset = proc_addr[1:0]
  - index = proc_addr[INDEX_W+1:2]
  - tag = proc_addr[29:INDEX_W+2], which is 28-INDEX_W bits
- Storage per line: one valid bit, a tag, and 128 data bits. The tag and data arrays have no reset; only the valid bits are reset.
- Reset (asynchronous, takes effect immediately):
  - all valid bits cleared
  - state set to IDLE
  - mem_read=0, mem_addr=0
  - hit_cnt=0, miss_cnt=0
  - proc_stall=0 and proc_rdata=0 while proc_read=0
- Hit = proc_read & valid[index] & (tag_arr[index]==tag), evaluated combinationally.
- IDLE state:
  - On a hit: proc_stall=0 and proc_rdata = the selected word of the line, in the same cycle (zero-latency hit). hit_cnt increments at the clock edge.
  - On a miss (proc_read=1 and not a hit): proc_stall=1 combinationally. At the clock edge the FSM latches proc_addr[29:2] into miss_line, increments miss_cnt, and moves to FETCH.
  - When proc_read=0: proc_stall=0, proc_rdata=0, no state change.
- FETCH state:
  - mem_read=1 and mem_addr=miss_line, held stable until mem_ready is sampled high.
  - proc_stall=1 and proc_rdata=0 throughout.
  - On the edge where mem_ready=1: write mem_rdata and the tag into line miss_line index, set its valid bit, and move to IDLE.
  - mem_read falls in the next cycle.
- Miss latency:
  - The miss is seen in cycle 0 and mem_read is high from cycle 1.
  - If mem_ready is high in cycle k, the re-lookup hits in cycle k+1 with stall=0.
  - Total stall is therefore k+1 cycles. The re-lookup cycle counts as a hit.
- The fill always uses the latched miss_line. Changes on proc_addr or proc_read during FETCH are ignored.
- mem_ready in IDLE is ignored; no array write occurs.
- A fill overwrites the indexed line unconditionally (replacement is implicit in direct mapping). Because the cache is read-only, no write-back is needed.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset during FETCH: mem_read drops asynchronously, the FSM returns to IDLE, and a later mem_ready pulse is ignored.
- Zero-latency memory (mem_ready high in the first FETCH cycle) is legal and gives a 2-cycle stall.

Test Plan:
- Reset, then proc_read=1, proc_addr=0:
  - stall=1 in cycle 0; mem_read=1 and mem_addr=0 from cycle 1.
  - Memory answers with mem_ready in cycle 3, words {w3,w2,w1,w0}={0x…0C,0x…08,0x…04,0x…00}.
  - Cycle 4: stall=0, proc_rdata=word0.
  - miss_cnt=1, hit_cnt=1.
- After that fill, sequential fetch of addresses 1, 2, 3 → three hits with stall=0 and the correct words; address 4 → miss with mem_addr=1.
- Conflict with INDEX_W=3:
  - Fetch word 0, then word 32 (same index, different tag) → miss, line replaced.
  - Refetch word 0 → miss again.
  - miss_cnt=3.
- During FETCH, change proc_addr to 0x100 and toggle proc_read → mem_addr stays at the original line and the fill is written to the original index.
- Reset asserted in the middle of FETCH:
  - mem_read=0 immediately, counters are 0.
  - A mem_ready pulse two cycles later leaves all valid bits clear.
  - A subsequent fetch of the same address misses.
- Stress with CNT_W=4: 20 hits → hit_cnt saturates at 15; a mem_ready pulse while idle → no change to the array or counters.
